// File: rtl/radio_enable_pkg.sv
// Purpose: shared types and limits for the multi-channel radio-enable sequencer.
// Contents: channel state enum, channel-count and synchroniser-depth limits.
package radio_enable_pkg;

  localparam int unsigned MAX_CH   = 16;
  localparam int unsigned MIN_SYNC = 2;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    WAIT_ON = 2'd1,
    ON      = 2'd2
  } radio_ch_state_e;

endpackage

// File: rtl/radio_enable_ch.sv
// Purpose: one radio channel. It synchronises the request into the clock domain,
//          applies the turn-on delay and the minimum on-time, and produces a
//          registered enable.
// Ports:
//   i_ck, i_arst     clock, asynchronous active-high reset
//   i_req_async      enable request, asynchronous to i_ck
//   i_force_off      synchronous kill; forces OFF and flushes the synchroniser
//   i_on_dly         turn-on delay, sampled only when the counter loads
//   i_min_on         minimum on-time extension, sampled only on ON entry
//   o_radio_enable   registered enable (state == ON)
//   o_busy           registered (state != OFF)
//   o_en_nxt_c       combinational next-state enable, feeds the popcount in the top
module radio_enable_ch
  import radio_enable_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             i_ck,
  input  logic             i_arst,
  input  logic             i_req_async,
  input  logic             i_force_off,
  input  logic [CNT_W-1:0] i_on_dly,
  input  logic [CNT_W-1:0] i_min_on,
  output logic             o_radio_enable,
  output logic             o_busy,
  output logic             o_en_nxt_c
);

  // A chain shallower than MIN_SYNC is not a safe synchroniser, so clamp it.
  localparam int unsigned SYNC_N = (SYNC_STAGES < MIN_SYNC) ? MIN_SYNC : SYNC_STAGES;

  logic [SYNC_N-1:0] r_sync;
  logic              w_req_s;
  radio_ch_state_e   r_state;
  radio_ch_state_e   w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_en;
  logic              r_busy;
  logic              w_en_nxt;
  logic              w_busy_nxt;

  assign w_req_s = r_sync[SYNC_N-1];

  // Request synchroniser. force_off also flushes it, so on release the request
  // is re-synchronised and the full turn-on latency applies again.
  always_ff @(posedge i_ck or posedge i_arst) begin
    if (i_arst) begin
      r_sync <= '0;
    end else if (i_force_off) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_N-2:0], i_req_async};
    end
  end

  // State register, counter and registered outputs.
  always_ff @(posedge i_ck or posedge i_arst) begin
    if (i_arst) begin
      r_state <= OFF;
      r_cnt   <= '0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_en    <= w_en_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (i_force_off) begin
      w_state_nxt = OFF;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        OFF: begin
          if (w_req_s) begin
            if (i_on_dly == '0) begin
              w_state_nxt = ON;
              w_cnt_nxt   = i_min_on;
            end else begin
              w_state_nxt = WAIT_ON;
              w_cnt_nxt   = i_on_dly;
            end
          end
        end
        WAIT_ON: begin
          if (!w_req_s) begin
            w_state_nxt = OFF;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = ON;
            w_cnt_nxt   = i_min_on;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        ON: begin
          // Exit uses the pre-edge counter value; the counter saturates at 0.
          if (!w_req_s && (r_cnt == '0)) begin
            w_state_nxt = OFF;
          end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = OFF;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output decode from the next state; registered alongside the state.
  always_comb begin
    w_en_nxt   = (w_state_nxt == ON);
    w_busy_nxt = (w_state_nxt != OFF);
  end

  assign o_radio_enable = r_en;
  assign o_busy         = r_busy;
  assign o_en_nxt_c     = w_en_nxt;

endmodule

// File: rtl/radio_enable_seq.sv
// Purpose: multi-channel radio-enable sequencer between the timing-engine request
//          logic and the radio front-end enable pins.
// Ports:
//   ck, arst       clock, asynchronous active-high reset
//   req_async      per-channel enable request, asynchronous to ck
//   force_off      synchronous global kill
//   on_dly         shared turn-on delay (cycles)
//   min_on         shared minimum on-time extension (cycles)
//   radio_enable   registered enable per channel
//   busy           per channel, state is not OFF
//   active_cnt     registered count of channels with radio_enable high
module radio_enable_seq
  import radio_enable_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                        ck,
  input  logic                        arst,
  input  logic [NUM_CH-1:0]           req_async,
  input  logic                        force_off,
  input  logic [CNT_W-1:0]            on_dly,
  input  logic [CNT_W-1:0]            min_on,
  output logic [NUM_CH-1:0]           radio_enable,
  output logic [NUM_CH-1:0]           busy,
  output logic [$clog2(NUM_CH+1)-1:0] active_cnt
);

  localparam int unsigned ACT_W = $clog2(NUM_CH + 1);
  // Instantiated channel count, clamped to MAX_CH; higher indices are tied off to 0.
  localparam int unsigned CH_N  = (NUM_CH > MAX_CH) ? MAX_CH : NUM_CH;

  logic [NUM_CH-1:0] w_en_nxt;
  logic [ACT_W-1:0]  w_pop;
  logic [ACT_W-1:0]  r_active_cnt;

  // Independent channel instances.
  for (genvar gi = 0; gi < CH_N; gi++) begin : g_ch
    radio_enable_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
    ) u_ch (
      .i_ck           (ck),
      .i_arst         (arst),
      .i_req_async    (req_async[gi]),
      .i_force_off    (force_off),
      .i_on_dly       (on_dly),
      .i_min_on       (min_on),
      .o_radio_enable (radio_enable[gi]),
      .o_busy         (busy[gi]),
      .o_en_nxt_c     (w_en_nxt[gi])
    );
  end

  for (genvar gi = CH_N; gi < NUM_CH; gi++) begin : g_unused
    assign radio_enable[gi] = 1'b0;
    assign busy[gi]         = 1'b0;
    assign w_en_nxt[gi]     = 1'b0;
  end

  // Popcount of the next-state enables so the count moves on the same edge.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_pop = w_pop + ACT_W'(w_en_nxt[i]);
    end
  end

  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      r_active_cnt <= '0;
    end else begin
      r_active_cnt <= w_pop;
    end
  end

  assign active_cnt = r_active_cnt;

endmodule

// File: tb/tb_radio_enable_seq.sv
module tb_radio_enable_seq;

  localparam int unsigned NUM_CH      = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned ACT_W       = $clog2(NUM_CH + 1);

  logic              ck = 1'b0;
  logic              arst;
  logic [NUM_CH-1:0] req_async;
  logic              force_off;
  logic [CNT_W-1:0]  on_dly;
  logic [CNT_W-1:0]  min_on;
  logic [NUM_CH-1:0] radio_enable;
  logic [NUM_CH-1:0] busy;
  logic [ACT_W-1:0]  active_cnt;

  int total = 0;
  int bad   = 0;

  always #5 ck = ~ck;

  radio_enable_seq #(
    .NUM_CH      (NUM_CH),
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CNT_W)
  ) dut (
    .ck           (ck),
    .arst         (arst),
    .req_async    (req_async),
    .force_off    (force_off),
    .on_dly       (on_dly),
    .min_on       (min_on),
    .radio_enable (radio_enable),
    .busy         (busy),
    .active_cnt   (active_cnt)
  );

  // Advance one active edge and settle just past it.
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic flush(input int n);
    req_async = '0;
    force_off = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    logic [NUM_CH*2+ACT_W-1:0] obs;
    arst = 1'b1; req_async = '0; force_off = 1'b0; on_dly = '0; min_on = '0;
    #12;
    total++; if (radio_enable !== 4'b0000) begin bad++; $display("FAIL reset_en got=%b exp=0000", radio_enable); end
    total++; if (busy !== 4'b0000) begin bad++; $display("FAIL reset_busy got=%b exp=0000", busy); end
    total++; if (active_cnt !== 3'd0) begin bad++; $display("FAIL reset_active got=%0d exp=0", active_cnt); end
    tick();
    arst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      obs = {radio_enable, busy, active_cnt};
      total++; if (obs !== '0) begin bad++; $display("FAIL idle k=%0d got=%h exp=0", k, obs); end
    end
  endtask

  task automatic test_turn_on_off();
    logic [NUM_CH-1:0] exp;
    on_dly = 8'd5; min_on = 8'd0; req_async = 4'b0010;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = (k >= 8) ? 4'b0010 : 4'b0000;
      total++; if (radio_enable !== exp) begin bad++; $display("FAIL turn_on edge=%0d got=%b exp=%b", k, radio_enable, exp); end
      if (k == 3) begin
        total++; if (busy !== 4'b0010) begin bad++; $display("FAIL wait_busy got=%b exp=0010", busy); end
      end
    end
    total++; if (active_cnt !== 3'd1) begin bad++; $display("FAIL turn_on_active got=%0d exp=1", active_cnt); end
    req_async = 4'b0000;
    for (int k = 1; k <= 3; k++) begin
      tick();
      exp = (k < 3) ? 4'b0010 : 4'b0000;
      total++; if (radio_enable !== exp) begin bad++; $display("FAIL turn_off edge=%0d got=%b exp=%b", k, radio_enable, exp); end
    end
    total++; if (active_cnt !== 3'd0) begin bad++; $display("FAIL turn_off_active got=%0d exp=0", active_cnt); end
    total++; if (busy !== 4'b0000) begin bad++; $display("FAIL turn_off_busy got=%b exp=0000", busy); end
    flush(4);
  endtask

  task automatic test_abort();
    logic [NUM_CH-1:0] exp_busy;
    on_dly = 8'd10; min_on = 8'd0; req_async = 4'b0100;
    for (int k = 1; k <= 14; k++) begin
      if (k == 7) req_async = 4'b0000;
      tick();
      exp_busy = (k >= 3 && k <= 8) ? 4'b0100 : 4'b0000;
      total++; if (radio_enable !== 4'b0000) begin bad++; $display("FAIL abort_en edge=%0d got=%b exp=0000", k, radio_enable); end
      total++; if (busy !== exp_busy) begin bad++; $display("FAIL abort_busy edge=%0d got=%b exp=%b", k, busy, exp_busy); end
    end
    flush(2);
  endtask

  task automatic test_min_on();
    logic [NUM_CH-1:0] exp;
    on_dly = 8'd0; min_on = 8'd7; req_async = 4'b1000;
    for (int k = 1; k <= 13; k++) begin
      if (k == 2) req_async = 4'b0000;
      tick();
      exp = (k >= 3 && k <= 10) ? 4'b1000 : 4'b0000;
      total++; if (radio_enable !== exp) begin bad++; $display("FAIL min_on edge=%0d got=%b exp=%b", k, radio_enable, exp); end
    end
    min_on = 8'd0;
    flush(2);
  endtask

  task automatic test_force_off();
    logic [NUM_CH-1:0] exp;
    on_dly = 8'd2; min_on = 8'd0; req_async = 4'b1111;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp = (k == 5) ? 4'b1111 : 4'b0000;
      total++; if (radio_enable !== exp) begin bad++; $display("FAIL all_on edge=%0d got=%b exp=%b", k, radio_enable, exp); end
    end
    total++; if (active_cnt !== 3'd4) begin bad++; $display("FAIL all_on_active got=%0d exp=4", active_cnt); end
    force_off = 1'b1;
    tick();
    force_off = 1'b0;
    total++; if (radio_enable !== 4'b0000) begin bad++; $display("FAIL force_en got=%b exp=0000", radio_enable); end
    total++; if (active_cnt !== 3'd0) begin bad++; $display("FAIL force_active got=%0d exp=0", active_cnt); end
    total++; if (busy !== 4'b0000) begin bad++; $display("FAIL force_busy got=%b exp=0000", busy); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp = (k == 5) ? 4'b1111 : 4'b0000;
      total++; if (radio_enable !== exp) begin bad++; $display("FAIL reenable edge=%0d got=%b exp=%b", k, radio_enable, exp); end
    end
    total++; if (active_cnt !== 3'd4) begin bad++; $display("FAIL reenable_active got=%0d exp=4", active_cnt); end
    force_off = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++; if ({radio_enable, busy} !== 8'h00) begin bad++; $display("FAIL force_hold edge=%0d got=%h exp=00", k, {radio_enable, busy}); end
    end
    flush(4);
    total++; if (radio_enable !== 4'b0000) begin bad++; $display("FAIL force_release got=%b exp=0000", radio_enable); end
  endtask

  task automatic test_dly_change();
    logic [NUM_CH-1:0] exp;
    logic [ACT_W-1:0]  exp_cnt;
    on_dly = 8'd5; min_on = 8'd0; req_async = 4'b0101;
    for (int k = 1; k <= 8; k++) begin
      if (k == 5) on_dly = 8'd2;
      tick();
      exp     = (k == 8) ? 4'b0101 : 4'b0000;
      exp_cnt = (k == 8) ? 3'd2 : 3'd0;
      total++; if (radio_enable !== exp) begin bad++; $display("FAIL dly_change edge=%0d got=%b exp=%b", k, radio_enable, exp); end
      total++; if (active_cnt !== exp_cnt) begin bad++; $display("FAIL dly_active edge=%0d got=%0d exp=%0d", k, active_cnt, exp_cnt); end
    end
    flush(4);
  endtask

  task automatic test_arst();
    on_dly = 8'd0; min_on = 8'd0; req_async = 4'b0001;
    for (int k = 1; k <= 3; k++) tick();
    total++; if (radio_enable !== 4'b0001) begin bad++; $display("FAIL arst_pre got=%b exp=0001", radio_enable); end
    #2;
    arst = 1'b1;
    #1;
    total++; if (radio_enable !== 4'b0000) begin bad++; $display("FAIL arst_en got=%b exp=0000", radio_enable); end
    total++; if (active_cnt !== 3'd0) begin bad++; $display("FAIL arst_active got=%0d exp=0", active_cnt); end
    req_async = 4'b0000;
    tick();
    arst = 1'b0;
    tick();
    total++; if ({radio_enable, busy} !== 8'h00) begin bad++; $display("FAIL arst_post got=%h exp=00", {radio_enable, busy}); end
  endtask

  initial begin
    test_reset();
    test_turn_on_off();
    test_abort();
    test_min_on();
    test_force_off();
    test_dly_change();
    test_arst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/radio_enable_seq.md
# radio_enable_seq

Parametrised, multi-channel successor to the single-bit radio-enable register in the timing engine. Each channel takes an asynchronous radio-enable request, synchronises it into `ck`, applies a programmable turn-on delay and a minimum on-time, and drives a registered `radio_enable` per channel. A global synchronous `force_off` kills all channels. The block sits between the timing-engine request logic and the radio front-end enable pins.

## Interface
Parameters:
- `NUM_CH`, 4: number of independent radio channels, 1..16.
- `SYNC_STAGES`, 2: synchroniser flops per request, 2..4.
- `CNT_W`, 8: width of the delay and on-time counters.

Ports:
- `ck`  in  1  clock.
- `arst`  in  1  reset, asynchronous, active-high.
- `req_async`  in  NUM_CH  per-channel enable request, asynchronous to `ck`.
- `force_off`  in  1  synchronous; when high, all channels go off.
- `on_dly`  in  CNT_W  turn-on delay in cycles, shared by all channels; quasi-static.
- `min_on`  in  CNT_W  minimum on-time extension in cycles, shared; quasi-static.
- `radio_enable`  out  NUM_CH  registered enable per channel.
- `busy`  out  NUM_CH  channel state is not OFF.
- `active_cnt`  out  $clog2(NUM_CH+1)  number of channels with `radio_enable` high, registered.

## Operation
- Per channel: `req_async` passes through a `SYNC_STAGES` flop chain. The last stage is `req_s`.
- Each channel FSM has states OFF, WAIT_ON and ON, plus a down-counter `cnt` of CNT_W bits.
- OFF:
  - If `req_s`=1 and `on_dly`=0, go to ON.
  - If `req_s`=1 and `on_dly`>0, go to WAIT_ON and load `cnt`=`on_dly`.
- WAIT_ON:
  - If `req_s`=0, abort to OFF. The enable never asserts.
  - Otherwise, if `cnt`==1, go to ON. Else decrement `cnt`.
- ON entry loads `cnt`=`min_on`.
- ON: `cnt` decrements each cycle and saturates at 0. Exit to OFF when `req_s`=0 and `cnt`==0, both evaluated before the edge.
- `radio_enable` = (state==ON). It is registered as part of the state, so there is no glitch path.
- `on_dly` and `min_on` are sampled only when `cnt` is loaded. Changing them mid-count has no effect on the running count.
- `force_off`=1 puts every channel in OFF at the next edge and clears `cnt`. This overrides all other transitions. While `force_off` is held, channels stay in OFF regardless of `req_s`.
- `active_cnt` is the registered popcount of the next-state `radio_enable` vector, so it updates on the same edge as `radio_enable`.
- Channels are fully independent. Simultaneous events on different channels are all honoured in the same cycle.

## Timing
- Reset values: all sync flops 0, all states OFF, `cnt`=0, `radio_enable`=0, `busy`=0, `active_cnt`=0.
- Turn-on latency: number the first edge that samples `req_async`=1 as edge 1. `radio_enable` rises at edge SYNC_STAGES+1+`on_dly`.
- Turn-off: `req_s` falls at edge SYNC_STAGES after `req_async` falls. `radio_enable` falls at the following edge, provided `cnt`==0 by then.
- Minimum high time is `min_on`+1 cycles, even for a one-cycle `req_s` pulse.
- A `req_s` pulse shorter than `on_dly` cycles produces no enable.
- `force_off`: `radio_enable` is 0 one edge after `force_off` is seen high. Release behaves as a fresh OFF state, so full turn-on latency applies.
- `arst` asserted mid-operation clears everything immediately. Deassertion must be synchronous to `ck`; that is the integrator's responsibility.

## Structure
- Package `radio_enable_pkg` holds:
  - the state enum `radio_ch_state_e` {OFF, WAIT_ON, ON};
  - the limits `MAX_CH`=16 and `MIN_SYNC`=2.
- Sub-module `radio_enable_ch` contains one channel: synchroniser, FSM and counter.
- The top generates `NUM_CH` instances of `radio_enable_ch` and computes the `active_cnt` popcount register.

## Test plan
- Reset, then all `req_async`=0 for 20 cycles -> all outputs stay 0. Assert `arst` while channel 0 is ON -> `radio_enable[0]`=0 immediately.
- SYNC_STAGES=2, `on_dly`=5, `min_on`=0, `req_async[1]`=1 from edge 1 -> `radio_enable[1]` rises at edge 8. Drop the request -> enable falls 3 edges later.
- `on_dly`=10, request held high for 6 cycles -> WAIT_ON aborts, `radio_enable` never asserts, `busy` returns to 0.
- `on_dly`=0, `min_on`=7, request pulse of 1 cycle -> `radio_enable` high for exactly 8 cycles.
- All 4 channels ON (`active_cnt`=4), then `force_off` pulse -> all enables 0 and `active_cnt`=0 next edge. Requests still high -> re-enable after SYNC_STAGES+1+`on_dly` edges.
- Change `on_dly` from 5 to 2 during WAIT_ON -> the original 5-cycle delay is honoured. Channels 0 and 2 are requested on the same edge -> both enable on the same edge and `active_cnt` steps 0->2.
